id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core. It captures decode-stage operands, immediate, register specifiers and control bits at each rising clock edge. It presents them to the execute stage: shift-amount select, operand muxes, ALU and destination-register select. It supports pipeline hold (stall) and bubble insertion (flush) under hazard-unit control.

## Interface
- DATA_W, 32, datapath width (operands, immediate, PC)
- CTRL_W, 5, ALUControl width
- clock  in  1  single core clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- StallE  in  1  hold current E-stage contents
- FlushE  in  1  load a bubble on the next edge
- ValidD  in  1  D-stage slot holds a real instruction
- RD1D, RD2D  in  DATA_W  register-file read data (rs, rt)
- SignImmD  in  DATA_W  sign-extended immediate; bits [10:6] carry sa
- PCPlus8D  in  DATA_W  link address
- RsD, RtD, RdD  in  5  register specifiers
- ALUControlD  in  CTRL_W  ALU opcode
- ShiftSrcD, ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD, LinkD  in  1  decoded control bits
- SrcAE, WriteDataE, SignImmE, PCPlus8E  out  DATA_W  registered RD1D, RD2D, SignImmD, PCPlus8D
- RsE, RtE, RdE  out  5  registered specifiers
- ALUControlE  out  CTRL_W
- ShiftSrcE, ALUSrcE, RegDstE, RegWriteE, MemtoRegE, MemWriteE, LinkE  out  1
- ValidE  out  1  E-stage slot holds a real instruction

## Operation
- All outputs are flops; no combinational input-to-output path.
- Per edge, priority: reset (async) > FlushE > StallE > load.
- Load (FlushE=0, StallE=0): every E output takes its D counterpart; ValidE <= ValidD.
- Stall (StallE=1, FlushE=0): every output holds its value, including ValidE.
- Flush (FlushE=1, StallE don't-care): the bubble is written.
  - All outputs become 0; ValidE=0.
  - The bubble has RegWriteE=0, MemWriteE=0, MemtoRegE=0 and ALUControlE=0 (sll $0,$0,0 equivalent), so it has no architectural side effects.
- Simultaneous FlushE and StallE: flush wins. The hazard unit uses this to kill a stalled load-use victim.
- ValidD=0 with a load: the data fields still load, and ValidE=0. The downstream stage gates side effects on ValidE. RegWriteE/MemWriteE are also forced to 0 when ValidD=0.
- Data pass-through is bit-exact; no sign or width conversion. Downstream takes the shift amount from SrcAE[4:0] or SignImmE[10:6].

## Timing
- Latency: 1 cycle. D inputs sampled at edge N appear on E outputs after edge N.
- Reset: asserting reset (0) asynchronously clears all outputs to 0, ValidE=0, independent of clock. Release is sampled normally; the first load occurs on the first edge with reset=1.
- Reset mid-stall: contents are cleared. After release, the block loads on the first edge where StallE=0.
- A stall lasting K cycles holds the outputs for exactly K edges. The load resumes on the first edge with StallE=0.
- Flush affects one edge only. The next edge with FlushE=0 and StallE=0 loads normally.

## Test plan
- Reset: drive random inputs with reset=0 and toggle clock.
  - All outputs stay 0 and ValidE=0.
  - Release reset with RD1D=32'h0000_0013, ValidD=1 -> SrcAE=32'h13 and ValidE=1 after one edge.
- Pass-through: load the sll $t0,$t1,3 encoding.
  - Inputs: SignImmD=32'h0000_00C0, ShiftSrcD=1, RdD=8, RegWriteD=1.
  - Response: after the edge, SignImmE[10:6]=5'd3, ShiftSrcE=1, RdE=8, RegWriteE=1.
- Stall: load A (RD1D=32'hAAAA_0001), then hold StallE=1 for 3 edges while RD1D=32'hBBBB_0002.
  - Response: SrcAE=32'hAAAA_0001 for all 3 cycles.
  - Response: SrcAE=32'hBBBB_0002 one edge after StallE drops.
- Flush: with RegWriteD=1, MemWriteD=1, ValidD=1, assert FlushE=1 for one edge.
  - Response: all outputs 0, ValidE=0.
  - Next edge with FlushE=0: the inputs load normally.
- Flush+stall: assert StallE=1 and FlushE=1 together -> a bubble is loaded, not a hold.
- Mid-cycle async reset: pulse reset low between edges -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage operands and control bits and
// presents them to execute, with hold (StallE) and bubble insertion (FlushE).
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [DATA_W-1:0] PCPlus8D,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  input  logic [CTRL_W-1:0] ALUControlD,
  input  logic              ShiftSrcD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              LinkD,
  output logic [DATA_W-1:0] SrcAE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [DATA_W-1:0] SignImmE,
  output logic [DATA_W-1:0] PCPlus8E,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic [CTRL_W-1:0] ALUControlE,
  output logic              ShiftSrcE,
  output logic              ALUSrcE,
  output logic              RegDstE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              LinkE,
  output logic              ValidE
);

  typedef struct packed {
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] sign_imm;
    logic [DATA_W-1:0] pc_plus8;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] alu_control;
    logic              shift_src;
    logic              alu_src;
    logic              reg_dst;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              link;
    logic              valid;
  } ex_stage_t;

  ex_stage_t ex_d, ex_q;

  // Flush beats stall so the hazard unit can kill a stalled load-use victim.
  always_comb begin
    // NOTE: default to the held value first so no path through this block infers a latch.
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (!StallE) begin
      ex_d.src_a       = RD1D;
      ex_d.write_data  = RD2D;
      ex_d.sign_imm    = SignImmD;
      ex_d.pc_plus8    = PCPlus8D;
      ex_d.rs          = RsD;
      ex_d.rt          = RtD;
      ex_d.rd          = RdD;
      ex_d.alu_control = ALUControlD;
      ex_d.shift_src   = ShiftSrcD;
      ex_d.alu_src     = ALUSrcD;
      ex_d.reg_dst     = RegDstD;
      ex_d.reg_write   = RegWriteD & ValidD;
      ex_d.mem_to_reg  = MemtoRegD;
      ex_d.mem_write   = MemWriteD & ValidD;
      ex_d.link        = LinkD;
      ex_d.valid       = ValidD;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign SrcAE       = ex_q.src_a;
  assign WriteDataE  = ex_q.write_data;
  assign SignImmE    = ex_q.sign_imm;
  assign PCPlus8E    = ex_q.pc_plus8;
  assign RsE         = ex_q.rs;
  assign RtE         = ex_q.rt;
  assign RdE         = ex_q.rd;
  assign ALUControlE = ex_q.alu_control;
  assign ShiftSrcE   = ex_q.shift_src;
  assign ALUSrcE     = ex_q.alu_src;
  assign RegDstE     = ex_q.reg_dst;
  assign RegWriteE   = ex_q.reg_write;
  assign MemtoRegE   = ex_q.mem_to_reg;
  assign MemWriteE   = ex_q.mem_write;
  assign LinkE       = ex_q.link;
  assign ValidE      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, stall, flush, flush+stall,
// invalid-slot gating and asynchronous reset between edges.
module tb_id_ex_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 5;
  localparam int VW     = 4 * DATA_W + 15 + CTRL_W + 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              StallE, FlushE, ValidD;
  logic [DATA_W-1:0] RD1D, RD2D, SignImmD, PCPlus8D;
  logic [4:0]        RsD, RtD, RdD;
  logic [CTRL_W-1:0] ALUControlD;
  logic              ShiftSrcD, ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD, LinkD;
  logic [DATA_W-1:0] SrcAE, WriteDataE, SignImmE, PCPlus8E;
  logic [4:0]        RsE, RtE, RdE;
  logic [CTRL_W-1:0] ALUControlE;
  logic              ShiftSrcE, ALUSrcE, RegDstE, RegWriteE, MemtoRegE, MemWriteE, LinkE, ValidE;

  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] exp_v, held_v;

  always #5 clock = ~clock;

  id_ex_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clock(clock), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .PCPlus8D(PCPlus8D),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
    .ShiftSrcD(ShiftSrcD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .LinkD(LinkD),
    .SrcAE(SrcAE), .WriteDataE(WriteDataE), .SignImmE(SignImmE), .PCPlus8E(PCPlus8E),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .ALUControlE(ALUControlE),
    .ShiftSrcE(ShiftSrcE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .LinkE(LinkE), .ValidE(ValidE)
  );

  wire [VW-1:0] e_all = {SrcAE, WriteDataE, SignImmE, PCPlus8E, RsE, RtE, RdE, ALUControlE,
                         ShiftSrcE, ALUSrcE, RegDstE, RegWriteE, MemtoRegE, MemWriteE,
                         LinkE, ValidE};

  // Expected E contents for a plain load of the current D inputs.
  function automatic logic [VW-1:0] load_vec();
    return {RD1D, RD2D, SignImmD, PCPlus8D, RsD, RtD, RdD, ALUControlD,
            ShiftSrcD, ALUSrcD, RegDstD, RegWriteD & ValidD, MemtoRegD,
            MemWriteD & ValidD, LinkD, ValidD};
  endfunction

  task automatic rand_d();
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom; PCPlus8D = $urandom;
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
    ALUControlD = CTRL_W'($urandom);
    {ShiftSrcD, ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD, LinkD} = 7'($urandom);
    ValidD = 1'b1; StallE = 1'b0; FlushE = 1'b0;
  endtask

  task automatic edge_sample();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rand_d();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      rand_d();
      edge_sample();
      n_cmp++;
      if (e_all !== '0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h want 0", i, e_all);
      end
    end
    @(negedge clock);
    rand_d();
    reset = 1'b1;
    RD1D  = 32'h0000_0013;
    ValidD = 1'b1;
    edge_sample();
    n_cmp++;
    if (SrcAE !== 32'h13 || ValidE !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got SrcAE=%h ValidE=%b want 00000013/1", SrcAE, ValidE);
    end
  endtask

  task automatic test_pass_through();
    @(negedge clock);
    rand_d();
    SignImmD = 32'h0000_00C0; ShiftSrcD = 1'b1; RdD = 5'd8; RegWriteD = 1'b1;
    exp_v = load_vec();
    edge_sample();
    n_cmp++;
    if (SignImmE[10:6] !== 5'd3 || ShiftSrcE !== 1'b1 || RdE !== 5'd8 || RegWriteE !== 1'b1) begin
      n_err++;
      $display("FAIL sll_fields: got sa=%0d shift=%b rd=%0d rw=%b want 3/1/8/1",
               SignImmE[10:6], ShiftSrcE, RdE, RegWriteE);
    end
    n_cmp++;
    if (e_all !== exp_v) begin
      n_err++;
      $display("FAIL sll_all: got %h want %h", e_all, exp_v);
    end
  endtask

  task automatic test_stall();
    @(negedge clock);
    rand_d();
    RD1D = 32'hAAAA_0001;
    held_v = load_vec();
    edge_sample();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      rand_d();
      RD1D = 32'hBBBB_0002;
      StallE = 1'b1;
      edge_sample();
      n_cmp++;
      if (SrcAE !== 32'hAAAA_0001 || e_all !== held_v) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, e_all, held_v);
      end
    end
    @(negedge clock);
    StallE = 1'b0;
    exp_v = load_vec();
    edge_sample();
    n_cmp++;
    if (SrcAE !== 32'hBBBB_0002 || e_all !== exp_v) begin
      n_err++;
      $display("FAIL stall_resume: got SrcAE=%h want BBBB0002", SrcAE);
    end
  endtask

  task automatic test_flush();
    @(negedge clock);
    rand_d();
    RegWriteD = 1'b1; MemWriteD = 1'b1; ValidD = 1'b1;
    FlushE = 1'b1;
    edge_sample();
    n_cmp++;
    if (e_all !== '0) begin
      n_err++;
      $display("FAIL flush_bubble: got %h want 0", e_all);
    end
    @(negedge clock);
    FlushE = 1'b0;
    exp_v = load_vec();
    edge_sample();
    n_cmp++;
    if (e_all !== exp_v) begin
      n_err++;
      $display("FAIL flush_next_load: got %h want %h", e_all, exp_v);
    end
  endtask

  task automatic test_flush_stall();
    @(negedge clock);
    rand_d();
    RegWriteD = 1'b1; ValidD = 1'b1;
    edge_sample();
    @(negedge clock);
    rand_d();
    StallE = 1'b1; FlushE = 1'b1;
    edge_sample();
    n_cmp++;
    if (e_all !== '0) begin
      n_err++;
      $display("FAIL flush_stall: got %h want 0", e_all);
    end
  endtask

  task automatic test_invalid_slot();
    @(negedge clock);
    rand_d();
    ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1;
    RD1D = 32'h1234_5678; MemtoRegD = 1'b1;
    edge_sample();
    n_cmp++;
    if (SrcAE !== 32'h1234_5678 || MemtoRegE !== 1'b1 || RegWriteE !== 1'b0 ||
        MemWriteE !== 1'b0 || ValidE !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_slot: got SrcAE=%h m2r=%b rw=%b mw=%b v=%b want 12345678/1/0/0/0",
               SrcAE, MemtoRegE, RegWriteE, MemWriteE, ValidE);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    rand_d();
    RD1D = 32'hFFFF_FFFF;
    edge_sample();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (e_all !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0", e_all);
    end
    @(negedge clock);
    StallE = 1'b1;
    edge_sample();
    @(negedge clock);
    reset = 1'b1;
    edge_sample();
    n_cmp++;
    if (e_all !== '0) begin
      n_err++;
      $display("FAIL reset_stall_hold: got %h want 0", e_all);
    end
    @(negedge clock);
    StallE = 1'b0;
    exp_v = load_vec();
    edge_sample();
    n_cmp++;
    if (e_all !== exp_v) begin
      n_err++;
      $display("FAIL reset_stall_load: got %h want %h", e_all, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall();
    test_flush();
    test_flush_stall();
    test_invalid_slot();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
